// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_ripple_subtractor #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Bin,
  output logic [SIZE-1:0] D,
  output logic            Bout,
  output logic            busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic            Ovf,
`endif
  output logic            done
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] a_sr;
  logic [SIZE-1:0] b_sr;
  logic [SIZE-1:0] acc;
  logic            borrow;
  logic [CW-1:0]   cnt;

  logic a_bit, b_bit, d_bit, bo_bit, last, accept;

  always_comb begin
    a_bit  = a_sr[0];
    b_bit  = b_sr[0];
    d_bit  = a_bit ^ b_bit ^ borrow;
    bo_bit = (~a_bit & b_bit) | (~a_bit & borrow) | (b_bit & borrow);
    last   = (cnt == CW'(SIZE - 1));
    accept = start && (state != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      // IDLE and DONE both accept a new request with the same capture.
      state  <= RUN;
      a_sr   <= A;
      b_sr   <= B;
      borrow <= Bin;
      acc    <= '0;
      cnt    <= '0;
      D      <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo_bit;
          acc    <= {d_bit, acc[SIZE-1:1]};
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            D     <= {d_bit, acc[SIZE-1:1]};
            Bout  <= bo_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            Ovf   <= borrow ^ bo_bit;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
